// File: rtl/pio_input_capture.sv
// -----------------------------------------------------------------------------
// pio_input_capture
//
// Avalon-MM slave input port with an input synchronizer, per-bit edge capture
// (write-1-to-clear), a per-bit interrupt mask and a registered IRQ output.
//
// Register map on read. Unused upper bits read as 0.
//   0 : data        (synchronized in_port)
//   1 : direction   (always 0, input-only)
//   2 : irq mask
//   3 : edgecapture (write 1 to clear)
//
// Bus handshake: there is no wait-state or read strobe. A write happens on any
// clk edge where chipselect=1 and write_n=0. readdata is re-registered from
// the current address on every clk edge, giving one cycle of read latency.
// Reads have no side effects.
//
// Ports
//   clk        in   system clock, sole clock domain
//   reset      in   asynchronous, active-high reset
//   address    in   [1:0] register select
//   chipselect in   slave select
//   write_n    in   active-low write strobe, qualified by chipselect
//   writedata  in   [31:0] write data, bits above DATA_WIDTH ignored
//   in_port    in   [DATA_WIDTH-1:0] external inputs, asynchronous to clk
//   readdata   out  [31:0] registered read data
//   irq        out  registered interrupt request, active high
// -----------------------------------------------------------------------------
module pio_input_capture #(
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0,   // 0 rising, 1 falling, 2 any
    parameter int IRQ_TYPE    = 1    // 0 level, 1 edge
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [31:0]           readdata,
    output logic                  irq
);

    // Reject parameter values the logic below is not built for.
    generate
        if (DATA_WIDTH < 1 || DATA_WIDTH > 32) begin : g_bad_width
            $error("pio_input_capture: DATA_WIDTH must be 1..32");
        end
        if (SYNC_STAGES < 0 || SYNC_STAGES > 3) begin : g_bad_sync
            $error("pio_input_capture: SYNC_STAGES must be 0..3");
        end
        if (EDGE_TYPE < 0 || EDGE_TYPE > 2) begin : g_bad_edge
            $error("pio_input_capture: EDGE_TYPE must be 0..2");
        end
        if (IRQ_TYPE < 0 || IRQ_TYPE > 1) begin : g_bad_irq
            $error("pio_input_capture: IRQ_TYPE must be 0..1");
        end
    endgenerate

    localparam logic [2:0] WARM_MAX = 3'(SYNC_STAGES + 1);

    // ---------------------------------------------------------------- sync
    logic [DATA_WIDTH-1:0] sync_out;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign sync_out = in_port;
        end else begin : g_sync
            logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= '0;
                    end
                end else begin
                    sync_q[0] <= in_port;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign sync_out = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // ---------------------------------------------------------------- state
    logic [DATA_WIDTH-1:0] prev_q;
    logic [DATA_WIDTH-1:0] mask_q, mask_d;
    logic [DATA_WIDTH-1:0] ec_q, ec_d;
    logic [2:0]            warm_q, warm_d;
    logic [31:0]           rd_q, rd_d;
    logic                  irq_q, irq_d;

    logic                  wr_en;
    logic                  warm_done;
    logic [DATA_WIDTH-1:0] rise, fall, edge_sel, edge_det, clr;

    // Upper writedata bits are deliberately ignored when DATA_WIDTH < 32.
    logic unused_wdata;
    assign unused_wdata = ^writedata;

    assign wr_en = chipselect & ~write_n;

    // The counter must see the synchronizer and prev fill with post-reset
    // samples before edges are trusted; otherwise a pin already high at
    // reset release would look like a rising edge.
    assign warm_done = (warm_q == WARM_MAX);
    assign warm_d    = warm_done ? warm_q : warm_q + 3'd1;

    assign rise = sync_out & ~prev_q;
    assign fall = ~sync_out & prev_q;

    always_comb begin
        edge_sel = rise;
        case (EDGE_TYPE)
            1:       edge_sel = fall;
            2:       edge_sel = rise | fall;
            default: edge_sel = rise;
        endcase
    end

    assign edge_det = warm_done ? edge_sel : '0;

    always_comb begin
        mask_d = mask_q;
        clr    = '0;
        if (wr_en && address == 2'd2) mask_d = writedata[DATA_WIDTH-1:0];
        if (wr_en && address == 2'd3) clr    = writedata[DATA_WIDTH-1:0];
    end

    // New edges are OR-ed in after the clear, so a set wins a collision.
    assign ec_d = (ec_q & ~clr) | edge_det;

    // Edge mode looks at the post-update capture value, so irq rises on the
    // same clk edge that sets the bit. The mask is the registered one, so a
    // mask write reaches irq one cycle later.
    assign irq_d = (IRQ_TYPE == 0) ? |(sync_out & mask_q) : |(ec_d & mask_q);

    always_comb begin
        rd_d = '0;
        case (address)
            2'd0:    rd_d[DATA_WIDTH-1:0] = sync_out;
            2'd2:    rd_d[DATA_WIDTH-1:0] = mask_q;
            2'd3:    rd_d[DATA_WIDTH-1:0] = ec_q;
            default: rd_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= '0;
            mask_q <= '0;
            ec_q   <= '0;
            warm_q <= '0;
            rd_q   <= '0;
            irq_q  <= 1'b0;
        end else begin
            prev_q <= sync_out;
            mask_q <= mask_d;
            ec_q   <= ec_d;
            warm_q <= warm_d;
            rd_q   <= rd_d;
            irq_q  <= irq_d;
        end
    end

    assign readdata = rd_q;
    assign irq      = irq_q;

endmodule
